// File: rtl/tlb_ctrl_if.sv
// Request/result bus between a requester and tlb_ctrl.
interface tlb_ctrl_if #(
   parameter int TLBNUM = 16
);
   localparam int IW = $clog2(TLBNUM);

   logic          op_valid;
   logic          op_ready;
   logic [2:0]    op_code;
   logic [4:0]    op_inv;
   logic [IW-1:0] op_index;
   logic          op_ne;
   logic [18:0]   op_vppn;
   logic [5:0]    op_ps;
   logic [9:0]    op_asid;
   logic [26:0]   op_lo0;
   logic [26:0]   op_lo1;

   logic          res_valid;
   logic          res_err;
   logic          res_ne;
   logic [IW-1:0] res_index;
   logic [18:0]   res_vppn;
   logic [5:0]    res_ps;
   logic [9:0]    res_asid;
   logic [26:0]   res_lo0;
   logic [26:0]   res_lo1;

   modport master (
      output op_valid, op_code, op_inv, op_index, op_ne, op_vppn, op_ps, op_asid, op_lo0, op_lo1,
      input  op_ready, res_valid, res_err, res_ne, res_index, res_vppn, res_ps, res_asid, res_lo0, res_lo1
   );

   modport slave (
      input  op_valid, op_code, op_inv, op_index, op_ne, op_vppn, op_ps, op_asid, op_lo0, op_lo1,
      output op_ready, res_valid, res_err, res_ne, res_index, res_vppn, res_ps, res_asid, res_lo0, res_lo1
   );
endinterface

// File: rtl/tlb_ctrl.sv
// TLB maintenance controller: sequences SRCH/RD/WR/FILL/INV requests onto
// the TLB search/read/write/invalidate ports with a fixed 3-cycle turnaround.
module tlb_ctrl #(
   parameter  int TLBNUM = 16,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          reset,
   tlb_ctrl_if.slave     bus,
   output logic [18:0]   tlb_s_vppn,
   output logic [9:0]    tlb_s_asid,
   input  logic          tlb_s_found,
   input  logic [IW-1:0] tlb_s_index,
   output logic [IW-1:0] tlb_r_index,
   input  logic          tlb_r_e,
   input  logic [18:0]   tlb_r_vppn,
   input  logic [5:0]    tlb_r_ps,
   input  logic [9:0]    tlb_r_asid,
   input  logic          tlb_r_g,
   input  logic [25:0]   tlb_r_lo0,
   input  logic [25:0]   tlb_r_lo1,
   output logic          tlb_we,
   output logic [IW-1:0] tlb_w_index,
   output logic          tlb_w_e,
   output logic [18:0]   tlb_w_vppn,
   output logic [5:0]    tlb_w_ps,
   output logic [9:0]    tlb_w_asid,
   output logic          tlb_w_g,
   output logic [25:0]   tlb_w_lo0,
   output logic [25:0]   tlb_w_lo1,
   output logic          tlb_inv_valid,
   output logic [4:0]    tlb_inv_op
);
   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   state_t        state, state_nxt;
   logic [IW-1:0] fill_ptr;

   logic [2:0]    lat_code;
   logic [4:0]    lat_inv;
   logic [IW-1:0] lat_index;
   logic          lat_ne;
   logic [18:0]   lat_vppn;
   logic [5:0]    lat_ps;
   logic [9:0]    lat_asid;
   logic [26:0]   lat_lo0;
   logic [26:0]   lat_lo1;

   logic accept, is_write, ps_ok, op_err;

   assign accept   = (state == IDLE) && bus.op_valid;
   assign is_write = (lat_code == OP_WR) || (lat_code == OP_FILL);
   assign ps_ok    = (lat_ps == 6'd12) || (lat_ps == 6'd22);
   // Anything the TLB cannot act on is reported instead of issued.
   assign op_err   = (lat_code > OP_INV) || (is_write && !ps_ok) ||
                     ((lat_code == OP_INV) && (lat_inv > 5'd6));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: fixed walk, one cycle per state once accepted.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.op_valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: TLB ports are driven only in ISSUE, so reset kills them at once.
   always_comb begin
      bus.op_ready  = (state == IDLE);
      bus.res_valid = (state == DONE);
      tlb_s_vppn    = '0;
      tlb_s_asid    = '0;
      tlb_r_index   = '0;
      tlb_we        = 1'b0;
      tlb_w_index   = '0;
      tlb_w_e       = 1'b0;
      tlb_w_vppn    = '0;
      tlb_w_ps      = '0;
      tlb_w_asid    = '0;
      tlb_w_g       = 1'b0;
      tlb_w_lo0     = '0;
      tlb_w_lo1     = '0;
      tlb_inv_valid = 1'b0;
      tlb_inv_op    = '0;
      if (state == ISSUE && !op_err) begin
         case (lat_code)
            OP_SRCH: begin
               tlb_s_vppn = lat_vppn;
               tlb_s_asid = lat_asid;
            end
            OP_RD: tlb_r_index = lat_index;
            OP_WR, OP_FILL: begin
               tlb_we      = 1'b1;
               tlb_w_index = (lat_code == OP_FILL) ? fill_ptr : lat_index;
               tlb_w_e     = ~lat_ne;
               tlb_w_vppn  = lat_vppn;
               tlb_w_ps    = lat_ps;
               tlb_w_asid  = lat_asid;
               tlb_w_g     = lat_lo0[26] & lat_lo1[26];
               tlb_w_lo0   = lat_lo0[25:0];
               tlb_w_lo1   = lat_lo1[25:0];
            end
            OP_INV: begin
               tlb_inv_valid = 1'b1;
               tlb_inv_op    = lat_inv;
               tlb_s_vppn    = lat_vppn;
               tlb_s_asid    = lat_asid;
            end
            default: ;
         endcase
      end
   end

   // Operand latch: captured only on accept so busy-time requests are ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_code  <= '0;
         lat_inv   <= '0;
         lat_index <= '0;
         lat_ne    <= 1'b0;
         lat_vppn  <= '0;
         lat_ps    <= '0;
         lat_asid  <= '0;
         lat_lo0   <= '0;
         lat_lo1   <= '0;
      end else if (accept) begin
         lat_code  <= bus.op_code;
         lat_inv   <= bus.op_inv;
         lat_index <= bus.op_index;
         lat_ne    <= bus.op_ne;
         lat_vppn  <= bus.op_vppn;
         lat_ps    <= bus.op_ps;
         lat_asid  <= bus.op_asid;
         lat_lo0   <= bus.op_lo0;
         lat_lo1   <= bus.op_lo1;
      end
   end

   // Round-robin fill pointer, advanced only by a FILL that actually wrote.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) fill_ptr <= '0;
      else if (state == ISSUE && lat_code == OP_FILL && !op_err)
         fill_ptr <= (fill_ptr == IW'(TLBNUM - 1)) ? '0 : fill_ptr + 1'b1;
   end

   // Result capture at the end of ISSUE; held until the next DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.res_err   <= 1'b0;
         bus.res_ne    <= 1'b0;
         bus.res_index <= '0;
         bus.res_vppn  <= '0;
         bus.res_ps    <= '0;
         bus.res_asid  <= '0;
         bus.res_lo0   <= '0;
         bus.res_lo1   <= '0;
      end else if (state == ISSUE) begin
         bus.res_err   <= op_err;
         bus.res_ne    <= 1'b0;
         bus.res_index <= '0;
         bus.res_vppn  <= '0;
         bus.res_ps    <= '0;
         bus.res_asid  <= '0;
         bus.res_lo0   <= '0;
         bus.res_lo1   <= '0;
         if (!op_err) begin
            if (lat_code == OP_SRCH) begin
               bus.res_ne    <= ~tlb_s_found;
               bus.res_index <= tlb_s_found ? tlb_s_index : '0;
            end else if (lat_code == OP_RD) begin
               if (tlb_r_e) begin
                  bus.res_vppn <= tlb_r_vppn;
                  bus.res_ps   <= tlb_r_ps;
                  bus.res_asid <= tlb_r_asid;
                  bus.res_lo0  <= {tlb_r_g, tlb_r_lo0};
                  bus.res_lo1  <= {tlb_r_g, tlb_r_lo1};
               end else begin
                  bus.res_ne   <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl: vector table plus scoreboard of results,
// with a small TLB array model answering the read port.
module tb_tlb_ctrl;
   localparam int TLBNUM = 16;
   localparam int IW     = $clog2(TLBNUM);

   typedef struct packed {
      logic          err;
      logic          ne;
      logic [IW-1:0] index;
      logic [18:0]   vppn;
      logic [5:0]    ps;
      logic [9:0]    asid;
      logic [26:0]   lo0;
      logic [26:0]   lo1;
   } res_t;

   typedef struct {
      logic [2:0]    code;
      logic [4:0]    inv;
      logic [IW-1:0] index;
      logic          ne;
      logic [18:0]   vppn;
      logic [5:0]    ps;
      logic [9:0]    asid;
      logic [26:0]   lo0;
      logic [26:0]   lo1;
      logic          s_found;
      logic [IW-1:0] s_index;
      logic          exp_we;
      logic [IW-1:0] exp_widx;
      logic          exp_inv;
      res_t          exp;
   } vec_t;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [25:0] lo0;
      logic [25:0] lo1;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   tlb_ctrl_if #(.TLBNUM(TLBNUM)) bus ();

   logic [18:0]   tlb_s_vppn;
   logic [9:0]    tlb_s_asid;
   logic          tlb_s_found;
   logic [IW-1:0] tlb_s_index;
   logic [IW-1:0] tlb_r_index;
   logic          tlb_r_e;
   logic [18:0]   tlb_r_vppn;
   logic [5:0]    tlb_r_ps;
   logic [9:0]    tlb_r_asid;
   logic          tlb_r_g;
   logic [25:0]   tlb_r_lo0, tlb_r_lo1;
   logic          tlb_we;
   logic [IW-1:0] tlb_w_index;
   logic          tlb_w_e;
   logic [18:0]   tlb_w_vppn;
   logic [5:0]    tlb_w_ps;
   logic [9:0]    tlb_w_asid;
   logic          tlb_w_g;
   logic [25:0]   tlb_w_lo0, tlb_w_lo1;
   logic          tlb_inv_valid;
   logic [4:0]    tlb_inv_op;

   tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
      .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
      .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn),
      .tlb_r_ps(tlb_r_ps), .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
      .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1),
      .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e),
      .tlb_w_vppn(tlb_w_vppn), .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid),
      .tlb_w_g(tlb_w_g), .tlb_w_lo0(tlb_w_lo0), .tlb_w_lo1(tlb_w_lo1),
      .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op)
   );

   // TLB array model: empty entries carry junk data with e = 0.
   ent_t mem [TLBNUM];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) mem[i] <= {1'b0, 19'h7FFFF, 6'h3F, 10'h3FF, 1'b1, 26'h3FFFFFF, 26'h3FFFFFF};
      end else if (tlb_we) begin
         mem[tlb_w_index] <= {tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g, tlb_w_lo0, tlb_w_lo1};
      end
   end
   assign tlb_r_e    = mem[tlb_r_index].e;
   assign tlb_r_vppn = mem[tlb_r_index].vppn;
   assign tlb_r_ps   = mem[tlb_r_index].ps;
   assign tlb_r_asid = mem[tlb_r_index].asid;
   assign tlb_r_g    = mem[tlb_r_index].g;
   assign tlb_r_lo0  = mem[tlb_r_index].lo0;
   assign tlb_r_lo1  = mem[tlb_r_index].lo1;

   int n_pass = 0;
   int n_chk  = 0;
   res_t sb [$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Scoreboard consumer: every result strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.res_valid) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL res_unexpected: got res_valid=1 want no result");
         end else begin
            res_t e;
            res_t a;
            e = sb.pop_front();
            a = {bus.res_err, bus.res_ne, bus.res_index, bus.res_vppn, bus.res_ps,
                 bus.res_asid, bus.res_lo0, bus.res_lo1};
            chk("res_fields", a, e);
         end
      end
   end

   function automatic res_t rs(logic err, logic ne, logic [IW-1:0] idx, logic [18:0] vppn,
                               logic [5:0] ps, logic [9:0] asid, logic [26:0] lo0, logic [26:0] lo1);
      return {err, ne, idx, vppn, ps, asid, lo0, lo1};
   endfunction

   function automatic vec_t mk(logic [2:0] code, logic [4:0] inv, logic [IW-1:0] idx, logic ne,
                               logic [18:0] vppn, logic [5:0] ps, logic [9:0] asid,
                               logic [26:0] lo0, logic [26:0] lo1, logic sf, logic [IW-1:0] si,
                               logic we, logic [IW-1:0] widx, logic invv, res_t exp);
      vec_t v;
      v.code = code; v.inv = inv; v.index = idx; v.ne = ne; v.vppn = vppn; v.ps = ps;
      v.asid = asid; v.lo0 = lo0; v.lo1 = lo1; v.s_found = sf; v.s_index = si;
      v.exp_we = we; v.exp_widx = widx; v.exp_inv = invv; v.exp = exp;
      return v;
   endfunction

   // One request: accept at T, strobes checked in T+1, result in T+2.
   // A conflicting WR is held on the bus while busy; it must be ignored.
   task automatic run_op(input vec_t v);
      @(negedge clk);
      chk("ready_idle", bus.op_ready, 1'b1);
      chk("res_valid_idle", bus.res_valid, 1'b0);
      bus.op_valid = 1'b1; bus.op_code = v.code; bus.op_inv = v.inv; bus.op_index = v.index;
      bus.op_ne = v.ne; bus.op_vppn = v.vppn; bus.op_ps = v.ps; bus.op_asid = v.asid;
      bus.op_lo0 = v.lo0; bus.op_lo1 = v.lo1;
      tlb_s_found = v.s_found; tlb_s_index = v.s_index;
      sb.push_back(v.exp);
      @(negedge clk);
      bus.op_code = 3'd2; bus.op_index = 4'd15; bus.op_ps = 6'd12; bus.op_ne = 1'b0;
      chk("ready_issue", bus.op_ready, 1'b0);
      chk("we_issue", tlb_we, v.exp_we);
      chk("inv_issue", tlb_inv_valid, v.exp_inv);
      if (v.exp_we) begin
         chk("w_index", tlb_w_index, v.exp_widx);
         chk("w_fields", {tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g, tlb_w_lo0, tlb_w_lo1},
             {~v.ne, v.vppn, v.ps, v.asid, v.lo0[26] & v.lo1[26], v.lo0[25:0], v.lo1[25:0]});
      end
      if (v.exp_inv) begin
         chk("inv_op", tlb_inv_op, v.inv);
         chk("inv_match", {tlb_s_vppn, tlb_s_asid}, {v.vppn, v.asid});
      end
      if (v.code == 3'd0) chk("s_drive", {tlb_s_vppn, tlb_s_asid}, {v.vppn, v.asid});
      if (v.code == 3'd1) chk("r_index", tlb_r_index, v.index);
      @(negedge clk);
      chk("done_strobes", {tlb_we, tlb_inv_valid, bus.res_valid, bus.op_ready}, 4'b0010);
      bus.op_valid = 1'b0;
   endtask

   vec_t vecs [$];

   initial begin
      int fidx;
      res_t r0;
      r0 = '0;
      // code inv idx ne vppn ps asid lo0 lo1 s_found s_index | we widx inv | result
      vecs.push_back(mk(2, 0, 3, 0, 19'h12345, 12, 10'h005, 27'h4012345, 27'h4054321, 0, 0, 1, 3, 0, r0));
      vecs.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                        rs(0, 0, 0, 19'h12345, 12, 10'h005, 27'h4012345, 27'h4054321)));
      vecs.push_back(mk(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rs(0, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(2, 0, 5, 1, 19'h00ABC, 22, 10'h3FF, 27'h4000001, 27'h0000003, 0, 0, 1, 5, 0, r0));
      vecs.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rs(0, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(2, 0, 6, 0, 19'h7FFFF, 22, 10'h3FF, 27'h4000001, 27'h0000003, 0, 0, 1, 6, 0, r0));
      vecs.push_back(mk(1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                        rs(0, 0, 0, 19'h7FFFF, 22, 10'h3FF, 27'h0000001, 27'h0000003)));
      vecs.push_back(mk(0, 0, 0, 0, 19'h12345, 0, 10'h005, 0, 0, 1, 9, 0, 0, 0, rs(0, 0, 9, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(0, 0, 0, 0, 19'h54321, 0, 10'h007, 0, 0, 0, 4, 0, 0, 0, rs(0, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(4, 5, 0, 0, 19'h12345, 0, 10'h005, 0, 0, 0, 0, 0, 0, 1, r0));
      vecs.push_back(mk(4, 7, 0, 0, 19'h12345, 0, 10'h005, 0, 0, 0, 0, 0, 0, 0, rs(1, 0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(6, 0, 2, 0, 19'h11111, 12, 10'h001, 0, 0, 1, 3, 0, 0, 0, rs(1, 0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(2, 0, 4, 0, 19'h22222, 14, 10'h002, 0, 0, 0, 0, 0, 0, 0, rs(1, 0, 0, 0, 0, 0, 0, 0)));
      // 17 good FILLs walk 0..15 then wrap; a bad-ps FILL after the fifth must not advance.
      fidx = 0;
      for (int i = 0; i < 17; i++) begin
         if (i == 5)
            vecs.push_back(mk(3, 0, 0, 0, 19'h3000, 14, 10'h010, 0, 0, 0, 0, 0, 0, 0,
                              rs(1, 0, 0, 0, 0, 0, 0, 0)));
         vecs.push_back(mk(3, 0, 0, 0, 19'h100 + 19'(i), 12, 10'h010, 27'h4000000 + 27'(i),
                           27'h4000100, 0, 0, 1, IW'(fidx), 0, r0));
         fidx = (fidx + 1) % TLBNUM;
      end

      bus.op_valid = 0; bus.op_code = 0; bus.op_inv = 0; bus.op_index = 0; bus.op_ne = 0;
      bus.op_vppn = 0; bus.op_ps = 0; bus.op_asid = 0; bus.op_lo0 = 0; bus.op_lo1 = 0;
      tlb_s_found = 0; tlb_s_index = 0;

      repeat (3) @(negedge clk);
      chk("rst_ready", bus.op_ready, 1'b1);
      chk("rst_strobes", {tlb_we, tlb_inv_valid, bus.res_valid, bus.res_err, bus.res_ne}, 5'b0);
      chk("rst_res_data", {bus.res_vppn, bus.res_asid, bus.res_lo0}, 56'h0);
      reset = 1'b0;

      foreach (vecs[k]) run_op(vecs[k]);

      // Reset hitting the ISSUE cycle of a WR.
      @(negedge clk);
      bus.op_valid = 1'b1; bus.op_code = 3'd2; bus.op_index = 4'd2; bus.op_ne = 1'b0;
      bus.op_vppn = 19'h0ABCD; bus.op_ps = 6'd12; bus.op_asid = 10'h00A;
      @(negedge clk);
      bus.op_valid = 1'b0;
      chk("pre_rst_we", tlb_we, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("rst_issue_strobes", {tlb_we, tlb_inv_valid, bus.res_valid}, 3'b000);
      chk("rst_issue_ready", bus.op_ready, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_no_res", bus.res_valid, 1'b0);
      end
      chk("post_rst_ready", bus.op_ready, 1'b1);
      run_op(mk(3, 0, 0, 0, 19'h0777, 22, 10'h020, 0, 0, 0, 0, 1, 0, 0, r0));
      @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
